// File: rtl/iterative_multi_shifter.sv
// Iterative shifter: SLL/SRL/SRA/ROR by shift_count, at most STEP positions per cycle.
// Latency: done pulses ceil(shift_count/STEP) cycles after the accepting edge (0 count -> next cycle).
// Backpressure: start is accepted only while ready (IDLE or DONE); starts while busy are dropped.
// Optional feature: define ITERATIVE_SHIFTER_STICKY_EN to add the sticky output.
module iterative_multi_shifter #(
    parameter int WIDTH       = 32,
    parameter int COUNT_WIDTH = 5,
    parameter int STEP        = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       in,
    input  logic [COUNT_WIDTH-1:0] shift_count,
    input  logic [1:0]             mode,
    output logic                   ready,
    output logic                   busy,
    output logic [WIDTH-1:0]       out,
    output logic                   done
`ifdef ITERATIVE_SHIFTER_STICKY_EN
    ,
    output logic                   sticky
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    state_t                 state;
    logic [COUNT_WIDTH-1:0] remaining;
    logic [1:0]             mode_q;
    logic [COUNT_WIDTH-1:0] step_amt;
    logic [31:0]            rot_back;
    logic [WIDTH-1:0]       shifted;
    logic                   accept;

    // A start counts only when the FSM is not mid-operation.
    assign accept = start && (state != SHIFT);

    // Status flags decode directly from the state register.
    assign ready = (state == IDLE) || (state == DONE);
    assign busy  = (state == SHIFT);
    assign done  = (state == DONE);

    // Amount moved this cycle: min(STEP, remaining); the final step may be partial.
    always_comb begin
        if (32'(remaining) < 32'(STEP)) begin
            step_amt = remaining;
        end else begin
            step_amt = COUNT_WIDTH'(STEP);
        end
        rot_back = 32'(WIDTH) - 32'(step_amt);
    end

    // One iteration of the latched operation applied to the current result.
    always_comb begin
        shifted = out;
        case (mode_q)
            MODE_SLL: shifted = out << step_amt;
            MODE_SRL: shifted = out >> step_amt;
            MODE_SRA: shifted = $signed(out) >>> step_amt;
            MODE_ROR: shifted = (out >> step_amt) | (out << rot_back);
            default:  shifted = out;
        endcase
    end

`ifdef ITERATIVE_SHIFTER_STICKY_EN
    localparam logic [WIDTH-1:0] ONES = '1;
    logic [WIDTH-1:0] lost_bits;

    // Bits falling off the end this iteration; rotation loses nothing.
    always_comb begin
        lost_bits = '0;
        case (mode_q)
            MODE_SLL:           lost_bits = out & ~(ONES >> step_amt);
            MODE_SRL, MODE_SRA: lost_bits = out & ~(ONES << step_amt);
            default:            lost_bits = '0;
        endcase
    end

    // Sticky accumulates discarded bits since the last accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky <= 1'b0;
        end else if (accept) begin
            sticky <= 1'b0;
        end else if (state == SHIFT) begin
            sticky <= sticky | (|lost_bits);
        end
    end
`endif

    // Control FSM and datapath registers; reset overrides any start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out       <= '0;
            remaining <= '0;
            mode_q    <= MODE_SLL;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        out       <= in;
                        remaining <= shift_count;
                        mode_q    <= mode;
                        state     <= (shift_count == '0) ? DONE : SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    out       <= shifted;
                    remaining <= remaining - step_amt;
                    if (remaining == step_amt) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_multi_shifter.sv
// Bench for iterative_multi_shifter: one STEP=1 and one STEP=4 instance.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_iterative_multi_shifter;

    localparam int CW = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_s [2];
    logic [31:0] in_s    [2];
    logic [CW-1:0] cnt_s [2];
    logic [1:0]  mode_s  [2];
    logic        ready_s [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic [31:0] out_s   [2];
`ifdef ITERATIVE_SHIFTER_STICKY_EN
    logic        sticky_s [2];
`endif

    int n_pass = 0;
    int n_tot  = 0;
    int step_of [2] = '{1, 4};

    always #5 clk = ~clk;

    iterative_multi_shifter #(.WIDTH(32), .COUNT_WIDTH(CW), .STEP(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start_s[0]), .in(in_s[0]),
        .shift_count(cnt_s[0]), .mode(mode_s[0]), .ready(ready_s[0]),
        .busy(busy_s[0]), .out(out_s[0]), .done(done_s[0])
`ifdef ITERATIVE_SHIFTER_STICKY_EN
        , .sticky(sticky_s[0])
`endif
    );

    iterative_multi_shifter #(.WIDTH(32), .COUNT_WIDTH(CW), .STEP(4)) u_s4 (
        .clk(clk), .rst(rst), .start(start_s[1]), .in(in_s[1]),
        .shift_count(cnt_s[1]), .mode(mode_s[1]), .ready(ready_s[1]),
        .busy(busy_s[1]), .out(out_s[1]), .done(done_s[1])
`ifdef ITERATIVE_SHIFTER_STICKY_EN
        , .sticky(sticky_s[1])
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Whole-operation result computed in one shot from the mode rules.
    function automatic logic [31:0] ref_res(input logic [31:0] a, input int c, input logic [1:0] m);
        int k;
        case (m)
            2'b00: return (c >= 32) ? 32'h0 : (a << c);
            2'b01: return (c >= 32) ? 32'h0 : (a >> c);
            2'b10: return (c >= 32) ? {32{a[31]}} : 32'($signed(a) >>> c);
            default: begin
                k = c % 32;
                if (k == 0) return a;
                return (a >> k) | (a << (32 - k));
            end
        endcase
    endfunction

    // Any original bit that leaves the word sets sticky; rotation never does.
    function automatic logic ref_stk(input logic [31:0] a, input int c, input logic [1:0] m);
        int lim;
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        lim  = (c > 32) ? 32 : c;
        if (m == 2'b11 || lim == 0) return 1'b0;
        if (m == 2'b00) return |(a & ~(ones >> lim));
        return |(a & ~(ones << lim));
    endfunction

    // Timing model: each accepted op finishes at a known edge number.
    int          ec = 0;
    int          done_at [2] = '{0, 0};
    logic [31:0] m_out   [2] = '{32'h0, 32'h0};
    logic        m_stk   [2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        ec = ec + 1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                done_at[d] = ec - 1;
                m_out[d]   = 32'h0;
                m_stk[d]   = 1'b0;
            end else if (start_s[d] && ec > done_at[d]) begin
                done_at[d] = ec + (int'(cnt_s[d]) + step_of[d] - 1) / step_of[d];
                m_out[d]   = ref_res(in_s[d], int'(cnt_s[d]), mode_s[d]);
                m_stk[d]   = ref_stk(in_s[d], int'(cnt_s[d]), mode_s[d]);
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("cyc%0d_busy%0d", ec, d), {31'h0, busy_s[d]}, {31'h0, ec < done_at[d]});
            chk($sformatf("cyc%0d_ready%0d", ec, d), {31'h0, ready_s[d]}, {31'h0, !(ec < done_at[d])});
            chk($sformatf("cyc%0d_done%0d", ec, d), {31'h0, done_s[d]}, {31'h0, ec == done_at[d]});
            if (!(ec < done_at[d])) begin
                chk($sformatf("cyc%0d_out%0d", ec, d), out_s[d], m_out[d]);
`ifdef ITERATIVE_SHIFTER_STICKY_EN
                chk($sformatf("cyc%0d_stk%0d", ec, d), {31'h0, sticky_s[d]}, {31'h0, m_stk[d]});
`endif
            end
        end
    end

    // Issue one op (called at posedge+1), then scramble inputs and time the completion.
    task automatic run_op(input int d, input logic [31:0] a, input int c, input logic [1:0] m,
                          input logic [31:0] exp_out, input int exp_n, input string name);
        int n;
        int bc;
        start_s[d] = 1'b1;
        in_s[d]    = a;
        cnt_s[d]   = CW'(c);
        mode_s[d]  = m;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
        in_s[d]    = $urandom;
        cnt_s[d]   = CW'($urandom);
        mode_s[d]  = 2'($urandom);
        n  = 0;
        bc = busy_s[d] ? 1 : 0;
        while (!done_s[d] && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (busy_s[d]) bc++;
        end
        chk({name, "_lat"}, 32'(n), 32'(exp_n));
        chk({name, "_busycyc"}, 32'(bc), 32'(exp_n));
        chk({name, "_out"}, out_s[d], exp_out);
    endtask

    initial begin
        int n;
        int pulses;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0; in_s[d] = 32'h0; cnt_s[d] = '0; mode_s[d] = 2'b00;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", {31'h0, ready_s[0]}, 32'h1);
        chk("rst_busy", {31'h0, busy_s[0]}, 32'h0);
        chk("rst_done", {31'h0, done_s[1]}, 32'h0);
        chk("rst_out", out_s[1], 32'h0);
        @(posedge clk); #1;

        // STEP=1 directed vectors
        run_op(0, 32'hF0F0_F0F0, 2, 2'b01, 32'h3C3C_3C3C, 2, "srl2");
        run_op(0, 32'h8000_0000, 4, 2'b10, 32'hF800_0000, 4, "sra4");
        @(posedge clk); #1;
        run_op(0, 32'hAAAA_AAAA, 3, 2'b00, 32'h5555_5550, 3, "sll3");
        run_op(0, 32'h0000_0001, 33, 2'b11, 32'h8000_0000, 33, "ror33");
        for (int m = 0; m < 4; m++) begin
            run_op(0, 32'hDEAD_BEEF, 0, 2'(m), 32'hDEAD_BEEF, 0, $sformatf("zero_m%0d", m));
            @(posedge clk); #1;
        end
        run_op(0, 32'h1234_5678, 40, 2'b01, 32'h0000_0000, 40, "srl40");
        run_op(0, 32'h8000_0001, 40, 2'b10, 32'hFFFF_FFFF, 40, "sra40");
        run_op(0, 32'h4000_0000, 31, 2'b10, 32'h0000_0000, 31, "sra31pos");

        // STEP=4 vectors, including a start pulse while busy
        run_op(1, 32'hFFFF_FFFF, 10, 2'b01, 32'h003F_FFFF, 3, "s4_srl10");
        run_op(1, 32'h1234_5678, 36, 2'b11, 32'h8123_4567, 9, "s4_ror36");
        run_op(1, 32'h0000_000F, 63, 2'b00, 32'h0000_0000, 16, "s4_sll63");
        run_op(1, 32'h8000_0000, 5, 2'b10, 32'hFC00_0000, 2, "s4_sra5");
        @(posedge clk); #1;
        start_s[1] = 1'b1; in_s[1] = 32'hFFFF_FFFF; cnt_s[1] = CW'(10); mode_s[1] = 2'b01;
        @(posedge clk); #1;
        chk("ign_busy", {31'h0, busy_s[1]}, 32'h1);
        in_s[1] = 32'h1234_5678; cnt_s[1] = CW'(1); mode_s[1] = 2'b00;
        @(posedge clk); #1;
        start_s[1] = 1'b0;
        n = 1;
        while (!done_s[1] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ign_lat", 32'(n), 32'd3);
        chk("ign_out", out_s[1], 32'h003F_FFFF);
        @(posedge clk); #1;

`ifdef ITERATIVE_SHIFTER_STICKY_EN
        run_op(0, 32'h0000_0004, 2, 2'b01, 32'h0000_0001, 2, "stk_a");
        chk("stk_a_sticky", {31'h0, sticky_s[0]}, 32'h0);
        run_op(0, 32'h0000_0005, 2, 2'b01, 32'h0000_0001, 2, "stk_b");
        chk("stk_b_sticky", {31'h0, sticky_s[0]}, 32'h1);
        run_op(0, 32'h0000_0005, 2, 2'b11, 32'h4000_0001, 2, "stk_c");
        chk("stk_c_sticky", {31'h0, sticky_s[0]}, 32'h0);
        @(posedge clk); #1;
`endif

        // back-to-back: second start issued in the DONE cycle
        run_op(0, 32'h0000_0001, 4, 2'b00, 32'h0000_0010, 4, "b2b_a");
        chk("b2b_in_done", {31'h0, done_s[0]}, 32'h1);
        run_op(0, 32'h0000_0100, 8, 2'b01, 32'h0000_0001, 8, "b2b_b");
        @(posedge clk); #1;

        // reset in the 2nd SHIFT cycle of count=8, with start asserted alongside
        start_s[0] = 1'b1; in_s[0] = 32'hFFFF_0000; cnt_s[0] = CW'(8); mode_s[0] = 2'b01;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy", {31'h0, busy_s[0]}, 32'h1);
        rst = 1'b1;
        start_s[0] = 1'b1; in_s[0] = 32'hABCD_0123; cnt_s[0] = CW'(0);
        @(posedge clk); #1;
        rst = 1'b0;
        start_s[0] = 1'b0;
        chk("mrst_out", out_s[0], 32'h0);
        chk("mrst_ready", {31'h0, ready_s[0]}, 32'h1);
        chk("mrst_busy", {31'h0, busy_s[0]}, 32'h0);
        chk("mrst_done", {31'h0, done_s[0]}, 32'h0);
        pulses = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done_s[0]) pulses++;
        end
        chk("mrst_no_done", 32'(pulses), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
